chx_rr_arbiter: RTL and testbench

Packet-level arbiter that sits directly downstream of the per-channel input controllers and consumes their `rr_req`/`rr_ack` streams. It selects one of `CH_NUM` requesting channels, with high-QoS channels served before low-QoS ones and round-robin order within each class. It then forwards the granted channel's packet byte-by-byte through a single registered output stage with ready/valid backpressure. A grant is held from SOP to EOP; packets from different channels are never interleaved.

---
 rtl/chx_rr_arbiter_if.sv | 39 +++
 rtl/chx_rr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_chx_rr_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chx_rr_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | chx_rr_arbiter_if                                                        |
// | Channel request/byte lanes in, single ready/valid byte stream out.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface chx_rr_arbiter_if #(
  parameter int CH_NUM = 8,
  parameter int DATA_W = 8,
  parameter int ID_W   = 3
);
  logic [CH_NUM-1:0]        ch_req;
  logic [CH_NUM-1:0]        ch_qos;
  logic [CH_NUM*DATA_W-1:0] ch_data;
  logic [CH_NUM-1:0]        ch_sop;
  logic [CH_NUM-1:0]        ch_eop;
  logic [CH_NUM-1:0]        ch_ack;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_sop;
  logic                     out_eop;
  logic                     out_qos;
  logic [ID_W-1:0]          out_ch_id;
  logic                     pkt_done;

  // Arbiter side
  modport master (
    input  ch_req, ch_qos, ch_data, ch_sop, ch_eop, out_ready,
    output ch_ack, out_valid, out_data, out_sop, out_eop, out_qos, out_ch_id, pkt_done
  );

  // Channel sources plus downstream sink
  modport slave (
    output ch_req, ch_qos, ch_data, ch_sop, ch_eop, out_ready,
    input  ch_ack, out_valid, out_data, out_sop, out_eop, out_qos, out_ch_id, pkt_done
  );
endinterface
`default_nettype wire

// File: rtl/chx_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | chx_rr_arbiter                                                           |
// | Two-class (QoS) round-robin packet arbiter with registered output stage. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module chx_rr_arbiter #(
  parameter int CH_NUM = 8,
  parameter int DATA_W = 8,
  parameter int ID_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  chx_rr_arbiter_if.master  arb_if
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam logic [ID_W-1:0] c_PTR_RST = ID_W'(CH_NUM - 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   g_q, g_d;
  logic              qos_q, qos_d;
  logic [ID_W-1:0]   hi_ptr_q, hi_ptr_d;
  logic [ID_W-1:0]   lo_ptr_q, lo_ptr_d;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_sop_q;
  logic              out_eop_q;

  logic [CH_NUM-1:0] w_hi_cand;
  logic [CH_NUM-1:0] w_ack;
  logic              w_ack_any;
  logic              w_sel_req;
  logic              w_sel_sop;
  logic              w_sel_eop;
  logic [DATA_W-1:0] w_sel_data;

  // First set bit of cand strictly after ptr, wrapping modulo CH_NUM.
  function automatic logic [ID_W-1:0] rr_pick(input logic [CH_NUM-1:0] cand,
                                               input logic [ID_W-1:0]   ptr);
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    logic            found;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= CH_NUM; k++) begin
      idx = ID_W'((int'(ptr) + k) % CH_NUM);
      if (!found && cand[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign w_hi_cand = arb_if.ch_req & arb_if.ch_qos;

  always_comb begin
    w_sel_req  = 1'b0;
    w_sel_sop  = 1'b0;
    w_sel_eop  = 1'b0;
    w_sel_data = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (g_q == ID_W'(i)) begin
        w_sel_req  = arb_if.ch_req[i];
        w_sel_sop  = arb_if.ch_sop[i];
        w_sel_eop  = arb_if.ch_eop[i];
        w_sel_data = arb_if.ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A byte is pulled only when the output register is empty or draining.
  assign w_ack_any = (state_q == XFER) && w_sel_req && (!out_valid_q || arb_if.out_ready);

  always_comb begin
    w_ack = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (g_q == ID_W'(i)) begin
        w_ack[i] = w_ack_any;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    qos_d    = qos_q;
    hi_ptr_d = hi_ptr_q;
    lo_ptr_d = lo_ptr_q;
    case (state_q)
      IDLE: begin
        if (|arb_if.ch_req) begin
          if (|w_hi_cand) begin
            g_d   = rr_pick(w_hi_cand, hi_ptr_q);
            qos_d = 1'b1;
          end else begin
            g_d   = rr_pick(arb_if.ch_req, lo_ptr_q);
            qos_d = 1'b0;
          end
          state_d = XFER;
        end
      end
      XFER: begin
        // Only the class that was served advances its pointer.
        if (w_ack_any && w_sel_eop) begin
          if (qos_q) begin
            hi_ptr_d = g_q;
          end else begin
            lo_ptr_d = g_q;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      g_q      <= '0;
      qos_q    <= 1'b0;
      hi_ptr_q <= c_PTR_RST;
      lo_ptr_q <= c_PTR_RST;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      qos_q    <= qos_d;
      hi_ptr_q <= hi_ptr_d;
      lo_ptr_q <= lo_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else if (w_ack_any) begin
      out_valid_q <= 1'b1;
      out_data_q  <= w_sel_data;
      out_sop_q   <= w_sel_sop;
      out_eop_q   <= w_sel_eop;
    end else if (out_valid_q && arb_if.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign arb_if.ch_ack    = w_ack;
  assign arb_if.out_valid = out_valid_q;
  assign arb_if.out_data  = out_data_q;
  assign arb_if.out_sop   = out_sop_q;
  assign arb_if.out_eop   = out_eop_q;
  assign arb_if.out_qos   = qos_q;
  assign arb_if.out_ch_id = g_q;
  assign arb_if.pkt_done  = w_ack_any && w_sel_eop;

endmodule
`default_nettype wire

// File: tb/tb_chx_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_chx_rr_arbiter                                                        |
// | Scoreboard bench: channel source model, expected byte and ack queues.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_chx_rr_arbiter;
  localparam int CH_NUM = 8;
  localparam int DATA_W = 8;
  localparam int ID_W   = 3;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } ibeat_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              qos;
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } obeat_t;

  typedef struct packed {
    logic [23:0]       cyc;
    logic [CH_NUM-1:0] mask;
  } ackev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  chx_rr_arbiter_if #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  chx_rr_arbiter #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (bus)
  );

  always #5 clk = ~clk;

  ibeat_t            src [CH_NUM][$];
  obeat_t            exp_q[$];
  ackev_t            exp_ack[$];
  int                done_log[$];
  int                hs_log[$];
  logic              rdy_q[$];
  logic [CH_NUM-1:0] stall;
  logic [CH_NUM-1:0] qos_cfg;
  logic              ack_sb_en;
  int                n_checks = 0;
  int                n_errors = 0;
  int                cyc = 0;
  int                ack_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_lanes();
    logic [CH_NUM-1:0]        req, sop, eop;
    logic [CH_NUM*DATA_W-1:0] data;
    req = '0; sop = '0; eop = '0; data = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (src[i].size() != 0) begin
        req[i] = !stall[i];
        sop[i] = src[i][0].sop;
        eop[i] = src[i][0].eop;
        data[i*DATA_W +: DATA_W] = src[i][0].data;
      end
    end
    bus.ch_req  = req;
    bus.ch_qos  = qos_cfg;
    bus.ch_sop  = sop;
    bus.ch_eop  = eop;
    bus.ch_data = data;
  endtask

  task automatic add_src(input int ch, input logic [7:0] base, input int len);
    ibeat_t b;
    for (int k = 0; k < len; k++) begin
      b.sop  = (k == 0);
      b.eop  = (k == len - 1);
      b.data = base + 8'(k);
      src[ch].push_back(b);
    end
  endtask

  task automatic add_exp(input int ch, input logic qos, input logic [7:0] base, input int len);
    obeat_t b;
    for (int k = 0; k < len; k++) begin
      b.id   = ID_W'(ch);
      b.qos  = qos;
      b.sop  = (k == 0);
      b.eop  = (k == len - 1);
      b.data = base + 8'(k);
      exp_q.push_back(b);
    end
  endtask

  task automatic expect_acks(input int c0, input int ch, input int n);
    ackev_t ev;
    for (int k = 0; k < n; k++) begin
      ev.cyc      = 24'(c0 + k);
      ev.mask     = '0;
      ev.mask[ch] = 1'b1;
      exp_ack.push_back(ev);
    end
  endtask

  // One clock: sample at the falling edge, update sources after the rising edge.
  task automatic tick();
    logic [CH_NUM-1:0] ack;
    obeat_t            got;
    ackev_t            ev;
    @(negedge clk);
    ack = bus.ch_ack;
    check_val("ack_onehot0", 32'($onehot0(ack)), 32'd1);
    check_val("ack_without_req", 32'(ack & ~bus.ch_req), 32'd0);
    if (bus.out_valid && !bus.out_ready) check_val("ack_while_full", 32'(ack), 32'd0);
    if (ack != 0) ack_cnt++;
    if (ack_sb_en && ack != 0) begin
      if (exp_ack.size() == 0) begin
        check_val("ack_unexpected", 32'(exp_ack.size()), 32'd1);
      end else begin
        ev.cyc  = cyc[23:0];
        ev.mask = ack;
        check_val("ack_seq", 32'(ev), 32'(exp_ack.pop_front()));
      end
    end
    if (bus.pkt_done) done_log.push_back(cyc);
    if (bus.out_valid) begin
      got.id   = bus.out_ch_id;
      got.qos  = bus.out_qos;
      got.sop  = bus.out_sop;
      got.eop  = bus.out_eop;
      got.data = bus.out_data;
      if (exp_q.size() == 0) begin
        check_val("out_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        check_val("out_beat", 32'(got), 32'(exp_q[0]));
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          hs_log.push_back(cyc);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < CH_NUM; i++) begin
      if (ack[i] && src[i].size() != 0) void'(src[i].pop_front());
    end
    if (rdy_q.size() != 0) bus.out_ready = rdy_q.pop_front();
    else bus.out_ready = 1'b1;
    drive_lanes();
  endtask

  function automatic logic busy();
    for (int i = 0; i < CH_NUM; i++) begin
      if (src[i].size() != 0) return 1'b1;
    end
    return (exp_q.size() != 0) || bus.out_valid;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, 32'(busy()), 32'd0);
  endtask

  task automatic wait_pops(input int ch, input int remaining, input int budget);
    int n;
    n = 0;
    while (src[ch].size() > remaining && n < budget) begin
      tick();
      n++;
    end
    check_val("pop_wait", 32'(src[ch].size()), 32'(remaining));
  endtask

  task automatic clear_model();
    for (int i = 0; i < CH_NUM; i++) src[i].delete();
    exp_q.delete();
    exp_ack.delete();
    done_log.delete();
    hs_log.delete();
    rdy_q.delete();
    stall     = '0;
    qos_cfg   = '0;
    ack_sb_en = 1'b0;
    drive_lanes();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_val({pfx, "_ack"},   32'(bus.ch_ack),    32'd0);
    check_val({pfx, "_valid"}, 32'(bus.out_valid), 32'd0);
    check_val({pfx, "_data"},  32'(bus.out_data),  32'd0);
    check_val({pfx, "_sop"},   32'(bus.out_sop),   32'd0);
    check_val({pfx, "_eop"},   32'(bus.out_eop),   32'd0);
    check_val({pfx, "_qos"},   32'(bus.out_qos),   32'd0);
    check_val({pfx, "_id"},    32'(bus.out_ch_id), 32'd0);
    check_val({pfx, "_done"},  32'(bus.pkt_done),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    bus.out_ready = 1'b1;
    clear_model();
    #1 rst = 1'b1;
    repeat (3) tick();
    check_outputs_zero("rst");
    rst = 1'b0;

    // Single low-QoS packet on channel 3.
    c = cyc;
    add_src(3, 8'h11, 4);
    add_exp(3, 1'b0, 8'h11, 4);
    expect_acks(c + 1, 3, 4);
    ack_sb_en = 1'b1;
    drive_lanes();
    drain("t1_drain", 40);
    check_val("t1_acks_left", 32'(exp_ack.size()), 32'd0);
    check_val("t1_done_cnt", 32'(done_log.size()), 32'd1);
    if (done_log.size() > 0) check_val("t1_done_cyc", 32'(done_log[0]), 32'(c + 4));
    check_val("t1_hs_cnt", 32'(hs_log.size()), 32'd4);
    if (hs_log.size() == 4) begin
      check_val("t1_first_out", 32'(hs_log[0]), 32'(c + 2));
      check_val("t1_last_out", 32'(hs_log[3]), 32'(c + 5));
    end

    // Round robin among channels 0, 2, 5 with channel 0 re-requesting.
    do_reset();
    c = cyc;
    add_src(0, 8'h20, 2);
    add_src(0, 8'h30, 2);
    add_src(2, 8'h40, 2);
    add_src(5, 8'h50, 2);
    add_exp(0, 1'b0, 8'h20, 2);
    add_exp(2, 1'b0, 8'h40, 2);
    add_exp(5, 1'b0, 8'h50, 2);
    add_exp(0, 1'b0, 8'h30, 2);
    expect_acks(c + 1, 0, 2);
    expect_acks(c + 4, 2, 2);
    expect_acks(c + 7, 5, 2);
    expect_acks(c + 10, 0, 2);
    ack_sb_en = 1'b1;
    drive_lanes();
    drain("t2_drain", 60);
    check_val("t2_acks_left", 32'(exp_ack.size()), 32'd0);

    // High-QoS channel 6 beats low-QoS channel 1.
    do_reset();
    qos_cfg[6] = 1'b1;
    c = cyc;
    add_src(1, 8'h60, 2);
    add_src(6, 8'h70, 3);
    add_exp(6, 1'b1, 8'h70, 3);
    add_exp(1, 1'b0, 8'h60, 2);
    expect_acks(c + 1, 6, 3);
    expect_acks(c + 5, 1, 2);
    ack_sb_en = 1'b1;
    drive_lanes();
    repeat (4) tick();
    check_val("t3_lo_ptr_mid", 32'(dut.lo_ptr_q), 32'd7);
    check_val("t3_hi_ptr_mid", 32'(dut.hi_ptr_q), 32'd6);
    drain("t3_drain", 40);
    check_val("t3_acks_left", 32'(exp_ack.size()), 32'd0);
    check_val("t3_lo_ptr_end", 32'(dut.lo_ptr_q), 32'd1);
    check_val("t3_done_cnt", 32'(done_log.size()), 32'd2);
    if (done_log.size() == 2) check_val("t3_done_cyc", 32'(done_log[1]), 32'(c + 6));

    // Output backpressure with out_ready 1,0,0,1,1 once data flows.
    do_reset();
    c = cyc;
    bus.out_ready = 1'b1;
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    add_src(4, 8'h80, 3);
    add_exp(4, 1'b0, 8'h80, 3);
    expect_acks(c + 1, 4, 2);
    expect_acks(c + 5, 4, 1);
    ack_sb_en = 1'b1;
    drive_lanes();
    drain("t4_drain", 40);
    check_val("t4_acks_left", 32'(exp_ack.size()), 32'd0);
    check_val("t4_hs_cnt", 32'(hs_log.size()), 32'd3);
    if (hs_log.size() == 3) begin
      check_val("t4_hs0", 32'(hs_log[0]), 32'(c + 2));
      check_val("t4_hs1", 32'(hs_log[1]), 32'(c + 5));
      check_val("t4_hs2", 32'(hs_log[2]), 32'(c + 6));
    end

    // Source stall: channel 2 drops its request for 3 cycles after byte 2 of 5.
    do_reset();
    add_src(2, 8'h90, 5);
    add_exp(2, 1'b0, 8'h90, 5);
    drive_lanes();
    wait_pops(2, 3, 20);
    stall[2] = 1'b1;
    drive_lanes();
    c = ack_cnt;
    repeat (3) tick();
    check_val("t5_stall_acks", 32'(ack_cnt - c), 32'd0);
    check_val("t5_grant_kept", 32'(bus.out_ch_id), 32'd2);
    stall[2] = 1'b0;
    drive_lanes();
    drain("t5_drain", 40);

    // Reset mid-packet after channel 0 already moved lo_ptr.
    do_reset();
    add_src(0, 8'hA0, 2);
    add_exp(0, 1'b0, 8'hA0, 2);
    drive_lanes();
    drain("t6_pre_drain", 40);
    add_src(4, 8'hB0, 6);
    add_exp(4, 1'b0, 8'hB0, 6);
    drive_lanes();
    wait_pops(4, 4, 20);
    rst = 1'b1;
    #1;
    check_outputs_zero("t6_rst");
    clear_model();
    repeat (2) tick();
    rst = 1'b0;
    add_src(0, 8'hC0, 2);
    add_src(4, 8'hD0, 2);
    add_exp(0, 1'b0, 8'hC0, 2);
    add_exp(4, 1'b0, 8'hD0, 2);
    drive_lanes();
    drain("t6_drain", 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
